// File: rtl/fxp_matmul_pkg.sv
// Shared types and elaboration-time helpers for the fixed-point matrix multiplier.
// Optional saturation is selected by defining FXP_MATMUL_SAT_EN.
package fxp_matmul_pkg;

    typedef enum logic [1:0] {StLoad, StCompute, StOut} state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Wide enough that DIM full-precision products can never wrap.
    function automatic int acc_width(input int width, input int dim);
        return 2 * width + clog2(dim);
    endfunction

    function automatic longint sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/fxp_mac.sv
// Signed multiply-accumulate with clear, plus Q-format shift and range check of the next sum.
// Defining FXP_MATMUL_SAT_EN clamps out-of-range results instead of wrapping.
module fxp_mac
    import fxp_matmul_pkg::*;
#(
    parameter int DIM   = 4,
    parameter int WIDTH = 16,
    parameter int QBITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    clr,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic        [WIDTH-1:0] res,
    output logic                    ovf
);
    localparam int ACCW = acc_width(WIDTH, DIM);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACCW-1:0]    acc_q;
    logic signed [ACCW-1:0]    acc_sum;
    logic signed [ACCW-1:0]    shifted;
    logic [ACCW-WIDTH:0]       hi;

    always_comb begin
        prod    = a * b;
        acc_sum = (clr ? '0 : acc_q) + {{(ACCW - 2 * WIDTH){prod[2*WIDTH-1]}}, prod};
        shifted = acc_sum >>> QBITS;
        hi      = shifted[ACCW-1:WIDTH-1];
        // In range only when every bit above the sign position matches the sign.
        ovf     = !((&hi) || !(|hi));
    end

`ifdef FXP_MATMUL_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

    always_comb begin
        res = shifted[WIDTH-1:0];
        if (ovf) res = shifted[ACCW-1] ? SAT_MIN : SAT_MAX;
    end
`else
    always_comb begin
        res = shifted[WIDTH-1:0];
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc_q <= '0;
        else if (en) acc_q <= acc_sum;
    end

endmodule

// File: rtl/fxp_matmul_engine.sv
// Time-multiplexed signed fixed-point DIMxDIM matrix multiplier with valid/ready streams.
// Define FXP_MATMUL_SAT_EN to saturate out-of-range results (default wraps).
module fxp_matmul_engine
    import fxp_matmul_pkg::*;
#(
    parameter int DIM   = 4,
    parameter int WIDTH = 16,
    parameter int QBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_last,
    output logic             busy
);
    localparam int NN = DIM * DIM;
    localparam int IW = clog2(DIM);
    localparam int AW = clog2(NN);
    localparam int WW = clog2(2 * NN);

    state_e           state;
    logic [WW-1:0]    wcnt;
    logic [IW-1:0]    i, j, k;
    logic [WIDTH-1:0] a_mem [NN];
    logic [WIDTH-1:0] b_mem [NN];
    logic [AW-1:0]    a_idx, b_idx;
    logic [WIDTH-1:0] mac_res;
    logic             mac_ovf;
    logic             in_hs, last_elem;

    assign in_hs     = (state == StLoad) && in_valid && in_ready;
    assign last_elem = (i == IW'(DIM - 1)) && (j == IW'(DIM - 1));
    assign a_idx     = AW'(int'(i) * DIM + int'(k));
    assign b_idx     = AW'(int'(k) * DIM + int'(j));

    always_ff @(posedge clk) begin
        if (in_hs) begin
            if (wcnt < WW'(NN)) a_mem[wcnt[AW-1:0]] <= in_data;
            else b_mem[AW'(wcnt - WW'(NN))] <= in_data;
        end
    end

    fxp_mac #(
        .DIM   (DIM),
        .WIDTH (WIDTH),
        .QBITS (QBITS)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .en    (state == StCompute),
        .clr   (k == '0),
        .a     (a_mem[a_idx]),
        .b     (b_mem[b_idx]),
        .res   (mac_res),
        .ovf   (mac_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StLoad;
            wcnt      <= '0;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                StLoad: begin
                    in_ready <= 1'b1;
                    if (in_hs) begin
                        if (wcnt == WW'(2 * NN - 1)) begin
                            wcnt     <= '0;
                            i        <= '0;
                            j        <= '0;
                            k        <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            state    <= StCompute;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                StCompute: begin
                    if (k == IW'(DIM - 1)) begin
                        // MAC output already includes this cycle's product.
                        k         <= '0;
                        out_valid <= 1'b1;
                        out_data  <= mac_res;
                        out_ovf   <= mac_ovf;
                        out_last  <= last_elem;
                        state     <= StOut;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (last_elem) begin
                            i        <= '0;
                            j        <= '0;
                            busy     <= 1'b0;
                            in_ready <= 1'b1;
                            state    <= StLoad;
                        end else begin
                            if (j == IW'(DIM - 1)) begin
                                j <= '0;
                                i <= i + 1'b1;
                            end else begin
                                j <= j + 1'b1;
                            end
                            state <= StCompute;
                        end
                    end
                end
                default: state <= StLoad;
            endcase
        end
    end

endmodule

// File: tb/tb_fxp_matmul_engine.sv
// Directed table-driven bench for fxp_matmul_engine (DIM=4 and DIM=2 instances).
module tb_fxp_matmul_engine;
    localparam int DIM = 4;
    localparam int W   = 16;
    localparam int NN  = DIM * DIM;

    typedef struct packed {
        logic [NN*W-1:0] a;
        logic [NN*W-1:0] b;
        logic [NN*W-1:0] c;
        logic [NN-1:0]   ovf;
        logic            rnd;
        logic [7:0]      stall;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid, in_ready, out_valid, out_ready, out_ovf, out_last, busy;
    logic [W-1:0]  in_data, out_data;
    logic          in_valid2, in_ready2, out_valid2, out_ready2, out_ovf2, out_last2, busy2;
    logic [7:0]    in_data2, out_data2;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   hs_cyc = 0;
    vec_t tv [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fxp_matmul_engine #(.DIM(4), .WIDTH(16), .QBITS(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
        .out_last(out_last), .busy(busy)
    );

    fxp_matmul_engine #(.DIM(2), .WIDTH(8), .QBITS(4)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .out_ovf(out_ovf2), .out_last(out_last2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send_mats(input int t);
        int n, guard;
        n = 0;
        guard = 0;
        while (n < 2 * NN && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (tv[t].rnd && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = (n < NN) ? tv[t].a[n*W +: W] : tv[t].b[(n-NN)*W +: W];
                if (in_ready) begin
                    hs_cyc = cyc;
                    n++;
                end
            end
        end
        if (n < 2 * NN) chk("load words accepted", n, 2 * NN);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input int t, input int cnt, input bit lat);
        int bound;
        logic [W-1:0] d0;
        logic o0;
        // Junk on the input while busy must be ignored.
        if (tv[t].rnd) begin
            in_valid = 1'b1;
            in_data  = 16'hDEAD;
        end
        for (int n = 0; n < cnt; n++) begin
            bound = 0;
            while (!out_valid && bound < 200) begin
                @(negedge clk);
                bound++;
            end
            if (!out_valid) begin
                chk("out_valid timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            if (lat && n == 0) chk("first out latency", cyc - hs_cyc, DIM + 1);
            chk($sformatf("c[%0d] data", n), out_data, tv[t].c[n*W +: W]);
            chk($sformatf("c[%0d] ovf", n), out_ovf, tv[t].ovf[n]);
            chk($sformatf("c[%0d] last", n), out_last, (n == NN - 1));
            chk($sformatf("c[%0d] busy/in_ready", n), {busy, in_ready}, 2'b10);
            if (n == NN - 1) in_valid = 1'b0;
            if (n == int'(tv[t].stall)) begin
                out_ready = 1'b0;
                d0 = out_data;
                o0 = out_ovf;
                repeat (7) begin
                    @(negedge clk);
                    chk("stall hold", {out_valid, in_ready, out_ovf, out_data}, {2'b10, o0, d0});
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
            chk($sformatf("c[%0d] valid drops", n), out_valid, 1'b0);
            if (n == NN - 1) chk("idle after last", {in_ready, busy}, 2'b10);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] bl [16];
        logic [7:0]  a2 [4];
        logic [7:0]  b2 [4];
        int i, j, bound;
        bl = '{16'h0100, 16'hFE80, 16'h0040, 16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF, 16'h1234,
               16'hEDCB, 16'h0200, 16'hFF00, 16'h0080, 16'h4000, 16'hC000, 16'h0003, 16'hFFFD};
        a2 = '{8'h10, 8'h20, 8'h30, 8'h40};
        b2 = '{8'h10, 8'h00, 8'h00, 8'h10};
        for (int t = 0; t < 4; t++) tv[t] = '0;
        for (int n = 0; n < NN; n++) begin
            i = n / DIM;
            j = n % DIM;
            tv[0].a[n*W +: W] = 16'h0100;
            tv[0].b[n*W +: W] = 16'h0200;
            tv[0].c[n*W +: W] = 16'h0800;
            tv[1].a[n*W +: W] = (i == j) ? 16'h0100 : 16'h0000;
            tv[1].b[n*W +: W] = bl[n];
            tv[1].c[n*W +: W] = bl[n];
            tv[2].a[n*W +: W] = 16'h0080;
            tv[2].b[n*W +: W] = (j == 0) ? 16'hFFFF : 16'h0000;
            tv[2].c[n*W +: W] = (j == 0) ? 16'hFFFE : 16'h0000;
            tv[3].a[n*W +: W] = 16'h7FFF;
            tv[3].b[n*W +: W] = 16'h7FFF;
`ifdef FXP_MATMUL_SAT_EN
            tv[3].c[n*W +: W] = 16'h7FFF;
`else
            tv[3].c[n*W +: W] = 16'hFC00;
`endif
        end
        tv[3].ovf   = '1;
        tv[0].stall = 8'hFF;
        tv[1].stall = 8'd5;
        tv[1].rnd   = 1'b1;
        tv[2].stall = 8'hFF;
        tv[3].stall = 8'd5;
        tv[3].rnd   = 1'b1;

        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset outputs", {in_ready, out_valid, out_ovf, out_last, busy, out_data}, '0);
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready after reset", {in_ready, busy}, 2'b10);

        // DIM=2 WIDTH=8 QBITS=4 instance: A times identity.
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            in_valid2 = 1'b1;
            in_data2  = (n < 4) ? a2[n] : b2[n-4];
            bound = 0;
            while (!in_ready2 && bound < 50) begin
                @(negedge clk);
                bound++;
            end
        end
        @(negedge clk);
        in_valid2 = 1'b0;
        for (int n = 0; n < 4; n++) begin
            bound = 0;
            while (!out_valid2 && bound < 50) begin
                @(negedge clk);
                bound++;
            end
            chk($sformatf("dim2 c[%0d] data", n), {out_valid2, out_data2}, {1'b1, a2[n]});
            chk($sformatf("dim2 c[%0d] last/ovf", n), {out_last2, out_ovf2}, {(n == 3), 1'b0});
            @(negedge clk);
        end

        for (int t = 0; t < 4; t++) begin
            send_mats(t);
            collect(t, NN, t == 0);
        end

        // Reset during COMPUTE of element 9, then run fresh operands.
        send_mats(0);
        collect(0, 9, 1'b0);
        @(negedge clk);
        chk("busy before reset", {busy, out_valid}, 2'b10);
        reset = 1'b1;
        #1;
        chk("reset drops outputs", {out_valid, busy, in_ready, out_last, out_ovf}, '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready after mid reset", {in_ready, busy}, 2'b10);
        send_mats(1);
        collect(1, NN, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fxp_matmul_engine.md
# fxp_matmul_engine

Parametrised signed fixed-point matrix multiplier that computes C = A × B for square DIM×DIM matrices. Operands arrive as a valid/ready word stream, A first and then B, each in row-major order. One multiply-accumulate is performed per cycle, and each C element is returned on a valid/ready output stream with an overflow sideband. It replaces the fixed 4×4 ROM-fed multiplier with a time-multiplexed engine that applies backpressure and can be reused at any size, width or Q format.

## Interface
- DIM, 4: matrix dimension; legal values are 2..16.
- WIDTH, 16: operand and result word width, signed two's complement.
- QBITS, 8: fractional bits. Must satisfy 0 ≤ QBITS < WIDTH.
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high. Clears all state.
- in_valid  in  1  in_data holds a valid operand word.
- in_ready  out  1  engine accepts a word; reset value 0.
- in_data  in  WIDTH  operand word (A words, then B words, row-major).
- out_valid  out  1  out_data holds a valid C element; reset value 0.
- out_ready  in  1  downstream accepts the C element.
- out_data  out  WIDTH  C[i][j], row-major order; reset value 0.
- out_ovf  out  1  the element in out_data exceeded the WIDTH range; reset value 0.
- out_last  out  1  marks C[DIM-1][DIM-1]; reset value 0.
- busy  out  1  high in COMPUTE or OUT state; reset value 0.

## Operation
- The FSM has three states.
  - LOAD: in_ready=1. Each handshake (in_valid && in_ready) writes the next slot. Words 0..DIM²-1 go to A and words DIM²..2·DIM²-1 go to B. On the handshake of word 2·DIM²-1 the next state is COMPUTE with i=j=k=0.
  - COMPUTE: each cycle, acc += A[i][k]·B[k][j]. acc is cleared when k=0. After k=DIM-1 the next state is OUT.
  - OUT: out_valid=1, with data held stable until out_ready.
    - On the handshake, advance j, and wrap j into i.
    - If the element was (DIM-1,DIM-1), go to LOAD. Otherwise go to COMPUTE.
- Arithmetic:
  - Products are full 2·WIDTH bits, signed.
  - The accumulator is ACCW = 2·WIDTH + clog2(DIM) bits, so it never wraps.
  - Result = acc >>> QBITS (arithmetic shift, truncation toward −∞). It is then range-checked against WIDTH signed.
  - out_ovf=1 when the result lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- In LOAD, in_valid with in_ready=0 is ignored. Input words are never dropped.
- A and B are overwritten on every LOAD pass. No output is produced until a full 2·DIM² words have been received.
- out_ready high outside OUT has no effect.
- Reset asserted in any state, including mid-COMPUTE or mid-OUT:
  - state goes to LOAD and all counters clear;
  - out_valid, out_last, out_ovf and busy go to 0 immediately;
  - the partial matrix is discarded.

## Timing
- in_ready rises on the first rising edge after reset deasserts, and stays high for the whole LOAD state.
- Let t be the cycle of the last B handshake. busy=1 from t+1. COMPUTE occupies t+1..t+DIM, and out_valid=1 at t+DIM+1.
- Per element: DIM compute cycles plus at least 1 OUT cycle. Best-case throughput is one element per DIM+1 cycles.
- Output handshake at cycle u:
  - If more elements remain, out_valid=0 at u+1 and the next element is valid at u+DIM+1.
  - If the element was the last, in_ready=1 and busy=0 at u+1.
- Total best-case latency from the last B word to the out_last handshake is DIM²·(DIM+1) cycles.
- Registered outputs: out_valid, out_data, out_ovf, out_last, busy and in_ready. None of them is combinational from inputs.

## Configuration
- FXP_MATMUL_SAT_EN defined:
  - an out-of-range result is clamped to 2^(WIDTH−1)−1 or −2^(WIDTH−1);
  - out_ovf is set.
- FXP_MATMUL_SAT_EN undefined:
  - out_data is the low WIDTH bits of the shifted result (wrap);
  - out_ovf is still set by the same range check.

## Structure
- Package fxp_matmul_pkg holds:
  - the state enum (LOAD, COMPUTE, OUT);
  - a clog2 function;
  - functions for ACCW and for the saturation limits as functions of WIDTH.
- Sub-module fxp_mac: a signed WIDTH×WIDTH multiply-accumulate with clear and an ACCW-bit accumulator, plus a shift/range-check/saturate output stage. The top level contains the operand storage, index counters, FSM and stream handshakes.

## Test plan
- All-ones case (DIM=4, WIDTH=16, QBITS=8):
  - Stimulus: A all 0x0100 (1.0), B all 0x0200 (2.0).
  - Response: 16 outputs of 0x0800 (8.0), out_ovf=0, out_last only on the 16th, first out_valid exactly DIM+1=5 cycles after the last B word.
- Identity and signed truncation:
  - Stimulus: A = identity (0x0100 on the diagonal) and B = arbitrary signed values including 0xFE80 (−1.5). Then A all 0x0080 (0.5) with B[k][0] = 0xFFFF.
  - Response: C equals B bit-exact for the identity case. For the second case, C[i][0] = 0xFFFE, because the 4 accumulated products of −1/512 sum to −1/128 in Q16 and floor division by 2^8 gives −2 LSB.
- Overflow:
  - Stimulus: A and B all 0x7FFF.
  - Response: out_ovf=1 on every element. out_data=0x7FFF with FXP_MATMUL_SAT_EN; with it undefined, out_data is the low 16 bits of (4·0x7FFF² >>> 8).
- Backpressure:
  - Stimulus: hold out_ready=0 for 7 cycles on element 5, and toggle in_valid randomly during LOAD.
  - Response: out_data and out_ovf are stable while stalled, no element is lost or duplicated, in_ready=0 throughout COMPUTE and OUT.
- Reset mid-operation:
  - Stimulus: assert reset during COMPUTE of element 9, then reload new A and B.
  - Response: out_valid and busy drop immediately, in_ready=1 one edge after release, and the results correspond only to the new operands.
- Parameter sweep:
  - Stimulus: instance with DIM=2, WIDTH=8, QBITS=4; A=[[0x10,0x20],[0x30,0x40]], B = identity (0x10).
  - Response: outputs 0x10, 0x20, 0x30, 0x40, with out_last on the 4th.
